// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL timer bank: default timer geometry and status padding.
package jtopl_pkg;

  localparam int unsigned JTOPL_TIMER_CW       = 8;
  localparam int unsigned JTOPL_TIMER_PRE_BASE = 2;
  localparam int unsigned JTOPL_TIMER_PRE_STEP = 2;
  localparam logic [4:0]  JTOPL_STATUS_PAD     = 5'd6;

  // log2 prescale applied to timer idx
  function automatic int unsigned jtopl_timer_pre(input int unsigned base,
                                                  input int unsigned step,
                                                  input int unsigned idx);
    return base + idx * step;
  endfunction

endpackage

// File: rtl/jtopl_timer_ch.sv
// One OPL timer: power-of-two prescaler, up-counter with reload, overflow pulse and flag.
// Optional JTOPL_TIMER_RDBACK_EN exposes the live counter for the bank readback mux.
module jtopl_timer_ch
  import jtopl_pkg::*;
#(
  parameter int unsigned CW  = JTOPL_TIMER_CW,
  parameter int unsigned PRE = JTOPL_TIMER_PRE_BASE
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cenop_i,
  input  logic          zero_i,
  input  logic [CW-1:0] value_i,
  input  logic          load_i,
  input  logic          flagen_i,
  input  logic          clr_flag_i,
  output logic          flag_o,
  output logic          overflow_o
`ifdef JTOPL_TIMER_RDBACK_EN
  ,
  output logic [CW-1:0] cnt_o
`endif
);

  localparam int unsigned PW = (PRE > 0) ? PRE : 1;

  logic [PW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_last_q;
  logic          flag_q, flag_d;
  logic          ovf_q, ovf_d;
  logic          tick, pre_term, step, wrap;

  always_comb begin
    tick     = zero_i & cenop_i;
    pre_term = (PRE == 0) ? 1'b1 : (&pre_q);
    // a load edge reloads instead of stepping, so stepping needs load held across two cenops
    step     = tick & load_i & load_last_q & pre_term;
    wrap     = step & (&cnt_q);

    pre_d  = pre_q;
    cnt_d  = cnt_q;
    flag_d = flag_q;
    ovf_d  = 1'b0;
    if (cenop_i) begin
      if (load_i && !load_last_q) begin
        cnt_d = value_i;
        pre_d = '0;
      end else if (load_i) begin
        if (tick) pre_d = pre_q + 1'b1;
        if (step) cnt_d = wrap ? value_i : cnt_q + 1'b1;
      end
      ovf_d = wrap;
      if (wrap && flagen_i) flag_d = 1'b1;
      else if (clr_flag_i)  flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_q       <= '0;
      cnt_q       <= '0;
      load_last_q <= 1'b0;
      flag_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
      if (cenop_i) load_last_q <= load_i;
    end
  end

  always_comb begin
    flag_o     = flag_q;
    overflow_o = ovf_q;
  end

`ifdef JTOPL_TIMER_RDBACK_EN
  always_comb cnt_o = cnt_q;
`endif

endmodule

// File: rtl/jtopl_timer_bank.sv
// Bank of NTIMERS OPL timers with IRQ reduction and status byte.
// JTOPL_TIMER_RDBACK_EN adds a registered counter readback port (rd_sel/rd_cnt).
module jtopl_timer_bank
  import jtopl_pkg::*;
#(
  parameter int unsigned NTIMERS  = 2,
  parameter int unsigned CW       = JTOPL_TIMER_CW,
  parameter int unsigned PRE_BASE = JTOPL_TIMER_PRE_BASE,
  parameter int unsigned PRE_STEP = JTOPL_TIMER_PRE_STEP,
  localparam int unsigned RSW     = (NTIMERS > 1) ? $clog2(NTIMERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cenop,
  input  logic                  zero,
  input  logic [NTIMERS*CW-1:0] value,
  input  logic [NTIMERS-1:0]    load,
  input  logic [NTIMERS-1:0]    flagen,
  input  logic [NTIMERS-1:0]    clr_flag,
  output logic [NTIMERS-1:0]    flag,
  output logic [NTIMERS-1:0]    overflow,
  output logic                  irq_n,
  output logic [7:0]            status
`ifdef JTOPL_TIMER_RDBACK_EN
  ,
  input  logic [RSW-1:0]        rd_sel,
  output logic [CW-1:0]         rd_cnt
`endif
);

`ifdef JTOPL_TIMER_RDBACK_EN
  logic [CW-1:0] cnt_w [NTIMERS];
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
`endif
  logic flag1;

  for (genvar i = 0; i < NTIMERS; i++) begin : g_ch
    jtopl_timer_ch #(
      .CW (CW),
      .PRE(jtopl_timer_pre(PRE_BASE, PRE_STEP, i))
    ) u_ch (
      .clk_i     (clk),
      .rst_i     (rst),
      .cenop_i   (cenop),
      .zero_i    (zero),
      .value_i   (value[i*CW +: CW]),
      .load_i    (load[i]),
      .flagen_i  (flagen[i]),
      .clr_flag_i(clr_flag[i]),
      .flag_o    (flag[i]),
      .overflow_o(overflow[i])
`ifdef JTOPL_TIMER_RDBACK_EN
      ,
      .cnt_o     (cnt_w[i])
`endif
    );
  end

  if (NTIMERS > 1) begin : g_flag1
    assign flag1 = flag[1];
  end else begin : g_noflag1
    assign flag1 = 1'b0;
  end

  always_comb begin
    irq_n  = ~|flag;
    status = {~irq_n, flag[0], flag1, JTOPL_STATUS_PAD};
  end

`ifdef JTOPL_TIMER_RDBACK_EN
  // out-of-range selects fall through to zero
  always_comb begin
    rd_cnt_d = '0;
    for (int unsigned k = 0; k < NTIMERS; k++) begin
      if (32'(rd_sel) == k) rd_cnt_d = cnt_w[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_cnt_q <= '0;
    else     rd_cnt_q <= rd_cnt_d;
  end

  always_comb rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_jtopl_timer_bank.sv
// Directed self-checking bench for jtopl_timer_bank (default bank plus a 4x10-bit bank).
module tb_jtopl_timer_bank;

  logic        clk = 1'b0;
  logic        rst, cenop, zero;

  logic [15:0] value;
  logic [1:0]  load, flagen, clr_flag, flag, overflow;
  logic        irq_n;
  logic [7:0]  status;

  logic [39:0] value2;
  logic [3:0]  load2, flagen2, clr2, flag2, ov2;
  logic        irq2;
  logic [7:0]  status2;

`ifdef JTOPL_TIMER_RDBACK_EN
  logic        rd_sel;
  logic [7:0]  rd_cnt;
  logic [1:0]  rd_sel2;
  logic [9:0]  rd_cnt2;
`endif

  int total = 0;
  int bad   = 0;
  int ovc0, ovc1, ovc3;
  logic flag0_at_ov;

  always #5 clk = ~clk;

  jtopl_timer_bank #(.NTIMERS(2), .CW(8)) dut (
    .clk(clk), .rst(rst), .cenop(cenop), .zero(zero),
    .value(value), .load(load), .flagen(flagen), .clr_flag(clr_flag),
    .flag(flag), .overflow(overflow), .irq_n(irq_n), .status(status)
`ifdef JTOPL_TIMER_RDBACK_EN
    , .rd_sel(rd_sel), .rd_cnt(rd_cnt)
`endif
  );

  jtopl_timer_bank #(.NTIMERS(4), .CW(10)) dut2 (
    .clk(clk), .rst(rst), .cenop(cenop), .zero(zero),
    .value(value2), .load(load2), .flagen(flagen2), .clr_flag(clr2),
    .flag(flag2), .overflow(ov2), .irq_n(irq2), .status(status2)
`ifdef JTOPL_TIMER_RDBACK_EN
    , .rd_sel(rd_sel2), .rd_cnt(rd_cnt2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk); #1;
  endtask

  // one sample tick (zero high for one clk) followed by a non-tick clk
  task automatic tick_n(input int n);
    repeat (n) begin
      zero = 1'b1;
      @(posedge clk); #1;
      if (overflow[0]) begin ovc0++; flag0_at_ov = flag[0]; end
      if (overflow[1]) ovc1++;
      if (ov2[3])      ovc3++;
      zero = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic restart0();
    load[0] = 1'b0; clk1();
    load[0] = 1'b1; clk1();
  endtask

  initial begin
    rst = 1'b1; cenop = 1'b1; zero = 1'b0;
    value = '0; load = '0; flagen = '0; clr_flag = '0;
    value2 = '0; load2 = '0; flagen2 = '0; clr2 = '0;
`ifdef JTOPL_TIMER_RDBACK_EN
    rd_sel = 1'b0; rd_sel2 = 2'd3;
`endif
    ovc0 = 0; ovc1 = 0; ovc3 = 0; flag0_at_ov = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flag", 32'(flag), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_irq_n", 32'(irq_n), 1);
    chk("rst_status", 32'(status), 32'h06);
    rst = 1'b0;
    clk1();

    // timer 1, value FE, flag disabled: 2 steps x 16 ticks
    value[15:8] = 8'hFE; load[1] = 1'b1;
    clk1();
    tick_n(31);
    chk("t1_no_ov_31", ovc1, 0);
    tick_n(1);
    chk("t1_ov_32", ovc1, 1);
    chk("t1_flag_off", 32'(flag[1]), 0);
    chk("t1_irq_n", 32'(irq_n), 1);
    tick_n(32);
    chk("t1_ov_64", ovc1, 2);
    chk("t1_status", 32'(status), 32'h06);
    load[1] = 1'b0;

    // timer 0, value FF: wrap every 4 ticks
    value[7:0] = 8'hFF; flagen[0] = 1'b1; load[0] = 1'b1;
    clk1();
    tick_n(3);
    chk("t0_no_ov_3", ovc0, 0);
    chk("t0_flag_pre", 32'(flag[0]), 0);
    tick_n(1);
    chk("t0_ov_4", ovc0, 1);
    chk("t0_flag", 32'(flag[0]), 1);
    chk("t0_irq_n", 32'(irq_n), 0);
    chk("t0_status", 32'(status), 32'hC6);
    tick_n(8);
    chk("t0_ov_12", ovc0, 3);

    // clear, then set-wins with clear held over a wrap
    clr_flag[0] = 1'b1;
    clk1();
    chk("clr_flag0", 32'(flag[0]), 0);
    chk("clr_irq_n", 32'(irq_n), 1);
    flag0_at_ov = 1'b0;
    tick_n(4);
    chk("setwin_ov", ovc0, 4);
    chk("setwin_flag", 32'(flag0_at_ov), 1);
    clr_flag[0] = 1'b0;
    tick_n(4);
    chk("reset_again_ov", ovc0, 5);
    chk("reset_again_flag", 32'(flag[0]), 1);
    clr_flag[0] = 1'b1; clk1(); clr_flag[0] = 1'b0;
    chk("pulse_clr_flag", 32'(flag[0]), 0);
    chk("pulse_clr_irq", 32'(irq_n), 1);
    chk("pulse_clr_status", 32'(status), 32'h06);

    // stop/restart with value F0: 16 steps x 4 ticks after reload
    value[7:0] = 8'hF0;
    restart0();
    ovc0 = 0;
    clk1();
`ifdef JTOPL_TIMER_RDBACK_EN
    chk("rd_after_load", 32'(rd_cnt), 32'hF0);
`endif
    tick_n(20);
    load[0] = 1'b0;
    tick_n(10);
    chk("stop_no_ov", ovc0, 0);
`ifdef JTOPL_TIMER_RDBACK_EN
    chk("rd_frozen", 32'(rd_cnt), 32'hF5);
`endif
    load[0] = 1'b1;
    clk1();
    tick_n(4);
`ifdef JTOPL_TIMER_RDBACK_EN
    chk("rd_step", 32'(rd_cnt), 32'hF1);
`endif
    tick_n(59);
    chk("restart_no_ov_63", ovc0, 0);
    tick_n(1);
    chk("restart_ov_64", ovc0, 1);
    chk("restart_flag", 32'(flag[0]), 1);

    // async reset while an overflow pulse and a flag are live
    value[7:0] = 8'hFF;
    restart0();
    tick_n(3);
    zero = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_ov", 32'(overflow[0]), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_flag", 32'(flag), 0);
    chk("mid_rst_irq_n", 32'(irq_n), 1);
    chk("mid_rst_status", 32'(status), 32'h06);
    zero = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ovc0 = 0;
    clk1();
    tick_n(3);
    chk("post_rst_no_ov", ovc0, 0);
    tick_n(1);
    chk("post_rst_ov", ovc0, 1);

    // 4x10-bit bank, timer 3 prescale 2^8, value 3FF
    value2[39:30] = 10'h3FF; flagen2[3] = 1'b1; load2[3] = 1'b1;
    clk1();
    ovc3 = 0;
    tick_n(1);
`ifdef JTOPL_TIMER_RDBACK_EN
    chk("rd2_cnt", 32'(rd_cnt2), 32'h3FF);
`endif
    tick_n(254);
    chk("b2_no_ov_255", ovc3, 0);
    tick_n(1);
    chk("b2_ov_256", ovc3, 1);
    chk("b2_flag3", 32'(flag2), 32'h8);
    chk("b2_irq_n", 32'(irq2), 0);
    chk("b2_status", 32'(status2), 32'h86);
    tick_n(256);
    chk("b2_ov_512", ovc3, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
